// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC source select encodings, branch condition codes
// and the controller state encoding used by the stage upstream of this one.
package cpu_pkg;

  // PC source select driven by the controller alongside pc_load
  typedef enum logic [1:0] {
    PCSEL_INC = 2'b00,  // PC + 1
    PCSEL_BR  = 2'b01,  // conditional branch, PC + sext(imm8)
    PCSEL_REG = 2'b10,  // PC <= C register (BX/BLX style)
    PCSEL_BL  = 2'b11   // unconditional branch, PC + sext(imm8)
  } pc_sel_e;

  // Branch condition field IR[10:8]; codes 5..7 are reserved and never taken
  typedef enum logic [2:0] {
    COND_B  = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_LT = 3'd3,
    COND_LE = 3'd4
  } cond_e;

  // Controller state encoding, kept here so both stages share one package
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_HALT    = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/pc_addr_unit_if.sv
// Bus between the controller/datapath and the PC/address stage.
interface pc_addr_unit_if #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              pc_reset;
  logic              pc_load;
  logic [1:0]        pc_sel;
  logic              addr_sel;
  logic              loadm;
  logic [2:0]        cond;
  logic [7:0]        imm8;
  logic              flag_n;
  logic              flag_z;
  logic              flag_v;
  logic [DATA_W-1:0] c_in;
  logic              halt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   mem_addr;
  logic              br_taken;
  logic [CNT_W-1:0]  fetch_cnt;

  // Controller / datapath side
  modport master (
    output pc_reset, pc_load, pc_sel, addr_sel, loadm, cond, imm8,
           flag_n, flag_z, flag_v, c_in, halt,
    input  pc, mem_addr, br_taken, fetch_cnt
  );

  // PC/address stage side
  modport slave (
    input  pc_reset, pc_load, pc_sel, addr_sel, loadm, cond, imm8,
           flag_n, flag_z, flag_v, c_in, halt,
    output pc, mem_addr, br_taken, fetch_cnt
  );
endinterface

// File: rtl/pc_addr_unit_branch_cond.sv
// Branch condition evaluator: maps IR condition code and N/Z/V to taken.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       taken
);

  // Signed compare conditions use N!=V as "less than"; reserved codes fall to 0
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_B:  taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = n ^ v;
      COND_LE: taken = (n ^ v) | z;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_addr_unit.sv
// PC register, data-address register, branch resolution, memory address mux
// and a saturating debug counter of sequential fetches.
module pc_addr_unit
  import cpu_pkg::*;
#(
  parameter int PC_W   = 9,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  pc_addr_unit_if.slave  bus
);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  da_q, da_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic             cond_taken;
  logic [PC_W-1:0]  br_target;

  branch_cond u_branch_cond (
    .cond  (bus.cond),
    .n     (bus.flag_n),
    .z     (bus.flag_z),
    .v     (bus.flag_v),
    .taken (cond_taken)
  );

  // PC already points past the branch, so the offset is added with no extra +1
  assign br_target = pc_q + {{(PC_W-8){bus.imm8[7]}}, bus.imm8};

  // Next-state for PC, branch flag and fetch counter (halt freezes all three)
  always_comb begin
    pc_d        = pc_q;
    br_taken_d  = br_taken_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!bus.halt && bus.pc_load) begin
      br_taken_d = 1'b0;
      if (bus.pc_reset) begin
        pc_d = '0;
      end else begin
        case (pc_sel_e'(bus.pc_sel))
          PCSEL_INC: begin
            pc_d = pc_q + 1'b1;
            if (fetch_cnt_q != {CNT_W{1'b1}}) begin
              fetch_cnt_d = fetch_cnt_q + 1'b1;
            end
          end
          PCSEL_BR: begin
            br_taken_d = cond_taken;
            if (cond_taken) begin
              pc_d = br_target;
            end
          end
          PCSEL_REG: pc_d = bus.c_in[PC_W-1:0];
          PCSEL_BL: begin
            br_taken_d = 1'b1;
            pc_d       = br_target;
          end
          default: pc_d = pc_q;
        endcase
      end
    end
  end

  // Data-address register loads from C regardless of halt
  always_comb begin
    da_d = bus.loadm ? bus.c_in[PC_W-1:0] : da_q;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= '0;
      da_q        <= '0;
      br_taken_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      da_q        <= da_d;
      br_taken_q  <= br_taken_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Outputs; pc shows the pre-update value during a load, giving the link address
  assign bus.pc        = pc_q;
  assign bus.mem_addr  = bus.addr_sel ? pc_q : da_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed bench for pc_addr_unit: a default instance plus a CNT_W=4 instance
// for counter saturation.
module tb_pc_addr_unit;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  pc_addr_unit_if #(.PC_W(9), .DATA_W(16), .CNT_W(16)) m ();
  pc_addr_unit_if #(.PC_W(9), .DATA_W(16), .CNT_W(4))  s ();

  pc_addr_unit #(.PC_W(9), .DATA_W(16), .CNT_W(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (m.slave)
  );

  pc_addr_unit #(.PC_W(9), .DATA_W(16), .CNT_W(4)) u_dut_small (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
  endtask

  // Advance one clock edge and settle just past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [2:0] cnd, input logic [7:0] imm);
    m.pc_load = 1'b1;
    m.pc_sel  = sel;
    m.cond    = cnd;
    m.imm8    = imm;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    m.pc_reset = 0; m.pc_load = 0; m.pc_sel = 0; m.addr_sel = 0; m.loadm = 0;
    m.cond = 0; m.imm8 = 0; m.flag_n = 0; m.flag_z = 0; m.flag_v = 0;
    m.c_in = 0; m.halt = 0;
    s.pc_reset = 0; s.pc_load = 0; s.pc_sel = 0; s.addr_sel = 0; s.loadm = 0;
    s.cond = 0; s.imm8 = 0; s.flag_n = 0; s.flag_z = 0; s.flag_v = 0;
    s.c_in = 0; s.halt = 0;

    #12;
    check("rst_pc", 32'(m.pc), 32'h0);
    check("rst_mem_addr", 32'(m.mem_addr), 32'h0);
    check("rst_br_taken", 32'(m.br_taken), 32'h0);
    check("rst_fetch_cnt", 32'(m.fetch_cnt), 32'h0);
    reset_n = 1'b1;

    // pc_reset load
    m.pc_reset = 1; m.addr_sel = 1;
    load(2'b00, 3'd0, 8'h00);
    check("pcrst_pc", 32'(m.pc), 32'h0);
    check("pcrst_mem_addr", 32'(m.mem_addr), 32'h0);
    check("pcrst_cnt", 32'(m.fetch_cnt), 32'h0);
    m.pc_reset = 0;

    // three sequential fetches
    load(2'b00, 3'd0, 8'h00);
    load(2'b00, 3'd0, 8'h00);
    load(2'b00, 3'd0, 8'h00);
    check("inc3_pc", 32'(m.pc), 32'h3);
    check("inc3_cnt", 32'(m.fetch_cnt), 32'h3);
    check("inc3_mem_addr", 32'(m.mem_addr), 32'h3);

    // BEQ taken backwards: 0x010 - 4
    m.c_in = 16'h0010;
    load(2'b10, 3'd0, 8'h00);
    check("ldreg_pc", 32'(m.pc), 32'h010);
    m.flag_z = 1;
    load(2'b01, 3'd1, 8'hFC);
    check("beq_t_pc", 32'(m.pc), 32'h00C);
    check("beq_t_br", 32'(m.br_taken), 32'h1);

    // BEQ not taken
    load(2'b10, 3'd0, 8'h00);
    check("ldreg_br_clr", 32'(m.br_taken), 32'h0);
    m.flag_z = 0;
    load(2'b01, 3'd1, 8'hFC);
    check("beq_nt_pc", 32'(m.pc), 32'h010);
    check("beq_nt_br", 32'(m.br_taken), 32'h0);
    check("br_cnt_unchanged", 32'(m.fetch_cnt), 32'h3);

    // BLE taken via N!=V
    m.flag_n = 1; m.flag_v = 0; m.flag_z = 0;
    load(2'b01, 3'd4, 8'h04);
    check("ble_t_pc", 32'(m.pc), 32'h014);
    check("ble_t_br", 32'(m.br_taken), 32'h1);

    // BLT not taken with N=V=1
    m.flag_n = 1; m.flag_v = 1;
    load(2'b01, 3'd3, 8'h04);
    check("blt_nt_pc", 32'(m.pc), 32'h014);
    check("blt_nt_br", 32'(m.br_taken), 32'h0);

    // BNE taken, then reserved code 110 never taken
    m.flag_n = 0; m.flag_v = 0; m.flag_z = 0;
    load(2'b01, 3'd2, 8'h04);
    check("bne_t_pc", 32'(m.pc), 32'h018);
    check("bne_t_br", 32'(m.br_taken), 32'h1);
    load(2'b01, 3'd6, 8'h05);
    check("c110_pc", 32'(m.pc), 32'h018);
    check("c110_br", 32'(m.br_taken), 32'h0);

    // PC wrap on increment
    m.c_in = 16'h01FF;
    load(2'b10, 3'd0, 8'h00);
    load(2'b00, 3'd0, 8'h00);
    check("wrap_inc_pc", 32'(m.pc), 32'h000);
    check("wrap_inc_cnt", 32'(m.fetch_cnt), 32'h4);

    // BL with negative offset wrapping below zero, cond ignored
    m.c_in = 16'h0002;
    load(2'b10, 3'd0, 8'h00);
    load(2'b11, 3'd5, 8'h80);
    check("bl_wrap_pc", 32'(m.pc), 32'h182);
    check("bl_wrap_br", 32'(m.br_taken), 32'h1);

    // DA load and mem_addr mux
    m.pc_load = 0; m.loadm = 1; m.addr_sel = 0; m.c_in = 16'hABCD;
    step();
    check("da_mem_addr", 32'(m.mem_addr), 32'h1CD);
    check("noload_pc", 32'(m.pc), 32'h182);
    check("noload_br", 32'(m.br_taken), 32'h1);
    m.loadm = 0;
    load(2'b10, 3'd0, 8'h00);
    check("ldreg_c_pc", 32'(m.pc), 32'h1CD);

    // halt blocks PC load and counting but not DA
    m.halt = 1; m.loadm = 1; m.c_in = 16'h0033;
    load(2'b00, 3'd0, 8'h00);
    check("halt_pc", 32'(m.pc), 32'h1CD);
    check("halt_cnt", 32'(m.fetch_cnt), 32'h4);
    check("halt_da", 32'(m.mem_addr), 32'h033);
    m.halt = 0; m.loadm = 0;

    // pc_reset without pc_load is ignored
    m.pc_load = 0; m.pc_reset = 1;
    step();
    check("pcrst_noload_pc", 32'(m.pc), 32'h1CD);
    m.pc_reset = 0;

    // simultaneous loadm and pc_load
    m.loadm = 1; m.c_in = 16'h0044;
    load(2'b00, 3'd0, 8'h00);
    check("simul_da", 32'(m.mem_addr), 32'h044);
    check("simul_cnt", 32'(m.fetch_cnt), 32'h5);
    m.loadm = 0; m.addr_sel = 1;
    #1;
    check("simul_pc_mux", 32'(m.mem_addr), 32'h1CE);
    load(2'b11, 3'd0, 8'h01);
    check("bl_pc", 32'(m.pc), 32'h1CF);
    m.pc_load = 0;

    // counter saturation on the narrow instance
    s.pc_load = 1; s.pc_sel = 2'b00;
    for (int i = 0; i < 15; i++) step();
    check("sat15_cnt", 32'(s.fetch_cnt), 32'hF);
    step();
    step();
    check("sat17_cnt", 32'(s.fetch_cnt), 32'hF);
    check("sat17_pc", 32'(s.pc), 32'h011);

    // asynchronous reset mid-cycle with strobes active
    m.pc_load = 1; m.pc_sel = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pc", 32'(m.pc), 32'h0);
    check("arst_mem_addr", 32'(m.mem_addr), 32'h0);
    check("arst_br", 32'(m.br_taken), 32'h0);
    check("arst_cnt", 32'(m.fetch_cnt), 32'h0);
    check("arst_small_cnt", 32'(s.fetch_cnt), 32'h0);
    step();
    check("arst_hold_pc", 32'(m.pc), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_addr_unit.md
Name: pc_addr_unit

Overview:
- Program-counter and memory-address generation stage, directly downstream of the controller FSM.
- Consumes the controller's pc_reset/pc_load/pc_sel/addr_sel/loadm strobes, the branch fields of the IR, the status flags and the datapath C value.
- Owns the PC register, the data-address register, branch-condition evaluation and the memory address mux.
- Also keeps a saturating retired-fetch counter for debug.

Parameters:
- PC_W, 9, width of PC, data-address register and memory address.
- DATA_W, 16, datapath word width (C input).
- CNT_W, 16, width of fetch counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- pc_reset  in  1  with pc_load, force PC to 0
- pc_load  in  1  update PC this cycle
- pc_sel  in  2  PC source: 00 PC+1, 01 conditional branch, 10 C register, 11 unconditional branch (BL)
- addr_sel  in  1  1: mem_addr=PC, 0: mem_addr=DA
- loadm  in  1  DA <= c_in[PC_W-1:0]
- cond  in  3  IR[10:8] branch condition
- imm8  in  8  IR[7:0] branch offset, two's complement
- flag_n, flag_z, flag_v  in  1 each  status register outputs
- c_in  in  DATA_W  datapath C register
- halt  in  1  controller halt indication
- pc  out  PC_W  current PC; also the link value for BL/BLX
- mem_addr  out  PC_W  memory address
- br_taken  out  1  registered: last pc_sel=01/11 load redirected PC
- fetch_cnt  out  CNT_W  count of PC increments (pc_sel=00 loads)

Behaviour:
- Reset (reset_n low, async): pc=0, DA=0, br_taken=0, fetch_cnt=0. Values hold until the first clk edge after deassertion.
- mem_addr is combinational: addr_sel ? pc : DA. It reflects PC/DA changes in the same cycle they register.
- PC update on clk edge, priority order:
  1. halt=1: PC holds, all loads ignored, br_taken holds.
  2. pc_load & pc_reset: PC <= 0.
  3. pc_load: PC per pc_sel.
  4. Otherwise PC holds.
- pc_reset without pc_load has no effect.
- pc_sel=00: PC <= PC+1, mod 2^PC_W; 2^PC_W-1 wraps to 0.
- pc_sel=01: target = PC + sext(imm8), mod 2^PC_W. PC already points past the branch, so no extra +1.
  - cond 000 always taken.
  - 001 taken if Z.
  - 010 taken if !Z.
  - 011 taken if N!=V.
  - 100 taken if (N!=V)|Z.
  - 101-111 never taken.
  - Not taken: PC holds.
- pc_sel=11: PC <= target unconditionally (cond ignored).
- pc_sel=10: PC <= c_in[PC_W-1:0]; upper bits are ignored.
- Link timing: pc output is the pre-update PC during the load cycle, so a same-cycle register write captures the return address.
- br_taken: updated only on pc_load with pc_sel 01/11, set to the taken result. Other loads clear it to 0.
- DA: loadm=1 captures c_in[PC_W-1:0], otherwise holds. Independent of halt.
- fetch_cnt: +1 on each effective pc_sel=00 load (not halted, not pc_reset). Saturates at 2^CNT_W-1. Cleared only by reset_n.
- Simultaneous loadm and pc_load: both take effect.
- Reset asserted mid-operation: immediate async clear of all state, regardless of strobes.

Decomposition:
- Shared cpu_pkg: pc_sel encodings (PCSEL_INC, PCSEL_BR, PCSEL_REG, PCSEL_BL) and branch cond codes (COND_B, COND_EQ, COND_NE, COND_LT, COND_LE). Same package as the controller's state constants.
- One combinational sub-module, branch_cond (cond, n, z, v -> taken), reused by any later pipelined variant.

Test Plan:
- Reset with pc_reset=1, pc_load=1, addr_sel=1 for 1 cycle -> pc=0, mem_addr=0. Then 3 pc_sel=00 loads -> pc=3, fetch_cnt=3.
- pc=0x010, cond=001, imm8=0xFC, Z=1, pc_sel=01 -> pc=0x00C, br_taken=1. Repeat from 0x010 with Z=0 -> pc stays 0x010, br_taken=0.
- cond=100 with N=1, V=0, Z=0 -> taken. cond=011 with N=V=1 -> not taken. cond=110 with imm8=5 -> not taken.
- pc=0x1FF, pc_sel=00 -> pc=0x000. pc=0x002, pc_sel=11, imm8=0x80 -> pc=0x182 (wrap).
- c_in=0xABCD, loadm=1, addr_sel=0 -> mem_addr=0x1CD. Then pc_sel=10 -> pc=0x1CD. halt=1 with pc_load -> pc unchanged.
- fetch_cnt preset near max (CNT_W=4 instance, 15 increments) -> saturates at 15. Assert reset_n low mid-cycle -> all outputs 0 before the next clk edge.
